// File: rtl/multicycle_controller.sv
// Main control FSM and ALU decoder that sequences a shared multicycle RISC-V datapath (lw, sw, R/I-type ALU, beq, jal).
// Latency: beq 3, R/I-type 4, jal 4, sw 4, lw 5 cycles from FETCH; all outputs are combinational from state and inputs.
// Backpressure: FETCH, MEMREAD and MEMWRITE hold until mem_ready; a held MEMWRITE keeps MemWrite asserted.
//
// Ports: clk/rst (async active-high); op, funct3, funct7b5 from the instruction register; zero from the ALU;
//        mem_ready memory handshake; datapath enables PCWrite, IRWrite, RegWrite, MemWrite; selects AdrSrc,
//        ResultSrc, ALUSrcA, ALUSrcB, ImmSrc; ALUControl; debug state; illegal_instr.
// Build option: MC_CTRL_ILLEGAL_TRAP_EN traps illegal opcodes in an absorbing HALT state; otherwise they act as NOPs.

module multicycle_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic [3:0] state,
    output logic       illegal_instr
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECUTER = 4'd6;
    localparam logic [3:0] S_ALUWB    = 4'd7;
    localparam logic [3:0] S_EXECUTEI = 4'd8;
    localparam logic [3:0] S_JAL      = 4'd9;
    localparam logic [3:0] S_BEQ      = 4'd10;
    localparam logic [3:0] S_HALT     = 4'd11;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    logic [3:0] state_q;
    logic [3:0] state_nxt;
    logic [1:0] alu_op;
    logic       pc_update;
    logic       branch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_nxt;
        end
    end

    assign state = state_q;

    // Moore outputs plus next-state; only the mem_ready-qualified strobes look at inputs.
    always_comb begin
        state_nxt = state_q;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        alu_op    = 2'b00;
        pc_update = 1'b0;
        branch    = 1'b0;
        case (state_q)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                // Async reset already holds the state at FETCH; gate the fetch strobes so
                // nothing is latched into PC or IR while rst is high.
                IRWrite   = mem_ready & ~rst;
                pc_update = mem_ready & ~rst;
                if (mem_ready) state_nxt = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_R:         state_nxt = S_EXECUTER;
                    OP_I:         state_nxt = S_EXECUTEI;
                    OP_JAL:       state_nxt = S_JAL;
                    OP_BEQ:       state_nxt = S_BEQ;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                    default:      state_nxt = S_HALT;
`else
                    default:      state_nxt = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                state_nxt = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (mem_ready) state_nxt = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                state_nxt = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                if (mem_ready) state_nxt = S_FETCH;
            end
            S_EXECUTER: begin
                ALUSrcA   = 2'b10;
                alu_op    = 2'b10;
                state_nxt = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                alu_op    = 2'b10;
                state_nxt = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite  = 1'b1;
                state_nxt = S_FETCH;
            end
            S_JAL: begin
                // Link value PC+4 is formed from OldPC; the target was already computed in DECODE.
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_update = 1'b1;
                state_nxt = S_ALUWB;
            end
            S_BEQ: begin
                ALUSrcA   = 2'b10;
                alu_op    = 2'b01;
                branch    = 1'b1;
                state_nxt = S_FETCH;
            end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            S_HALT: begin
                state_nxt = S_HALT;
            end
`endif
            default: begin
                state_nxt = S_FETCH;
            end
        endcase
    end

    assign PCWrite = pc_update | (branch & zero);

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    assign illegal_instr = (state_q == S_HALT);
`else
    assign illegal_instr = 1'b0;
`endif

    // Immediate format follows the opcode in every state so the extender is ready in DECODE.
    always_comb begin
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    // ALU decoder; op[5] separates R-type sub from addi, which has no funct7 field.
    always_comb begin
        ALUControl = 3'b000;
        case (alu_op)
            2'b01: ALUControl = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

    logic       clk;
    logic       rst;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;
    logic [1:0] ImmSrc;
    logic [3:0] state;
    logic       illegal_instr;

    int checks = 0;
    int errors = 0;

    multicycle_controller dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUControl(ALUControl), .ImmSrc(ImmSrc), .state(state),
        .illegal_instr(illegal_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (state !== 4'd0)      begin errors++; $display("FAIL rst_state got %0d exp 0", state); end
        checks++; if (PCWrite !== 1'b0)    begin errors++; $display("FAIL rst_pcwrite got %b exp 0", PCWrite); end
        checks++; if (IRWrite !== 1'b0)    begin errors++; $display("FAIL rst_irwrite got %b exp 0", IRWrite); end
        checks++; if (MemWrite !== 1'b0)   begin errors++; $display("FAIL rst_memwrite got %b exp 0", MemWrite); end
        checks++; if (RegWrite !== 1'b0)   begin errors++; $display("FAIL rst_regwrite got %b exp 0", RegWrite); end
        checks++; if (illegal_instr !== 1'b0) begin errors++; $display("FAIL rst_illegal got %b exp 0", illegal_instr); end
        checks++; if (ALUSrcB !== 2'b10)   begin errors++; $display("FAIL rst_alusrcb got %b exp 10", ALUSrcB); end
        checks++; if (ResultSrc !== 2'b10) begin errors++; $display("FAIL rst_resultsrc got %b exp 10", ResultSrc); end
        rst = 1'b0;
        #1;
        checks++; if (PCWrite !== 1'b1)    begin errors++; $display("FAIL fetch_pcwrite got %b exp 1", PCWrite); end
        checks++; if (IRWrite !== 1'b1)    begin errors++; $display("FAIL fetch_irwrite got %b exp 1", IRWrite); end
    endtask

    task automatic test_r_type(input logic f7);
        logic [3:0] st [5];
        logic       rw [5];
        logic [2:0] exp_alu;
        st = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
        rw = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        exp_alu = f7 ? 3'b001 : 3'b000;
        op = 7'b0110011; funct3 = 3'b000; funct7b5 = f7; mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (state !== st[i]) begin errors++; $display("FAIL rtype_state cyc%0d got %0d exp %0d", i, state, st[i]); end
            checks++; if (RegWrite !== rw[i]) begin errors++; $display("FAIL rtype_regwrite cyc%0d got %b exp %b", i, RegWrite, rw[i]); end
            checks++; if (MemWrite !== 1'b0) begin errors++; $display("FAIL rtype_memwrite cyc%0d got %b exp 0", i, MemWrite); end
            checks++; if (ImmSrc !== 2'b00) begin errors++; $display("FAIL rtype_immsrc cyc%0d got %b exp 00", i, ImmSrc); end
            if (i == 2) begin
                checks++; if (ALUControl !== exp_alu) begin errors++; $display("FAIL rtype_aluctl got %b exp %b", ALUControl, exp_alu); end
                checks++; if (ALUSrcA !== 2'b10) begin errors++; $display("FAIL rtype_alusrca got %b exp 10", ALUSrcA); end
                checks++; if (ALUSrcB !== 2'b00) begin errors++; $display("FAIL rtype_alusrcb got %b exp 00", ALUSrcB); end
            end
            if (i == 3) begin
                checks++; if (ResultSrc !== 2'b00) begin errors++; $display("FAIL aluwb_resultsrc got %b exp 00", ResultSrc); end
            end
            if (i < 4) next_cycle();
        end
    endtask

    // funct7b5 is held high: addi must still add because op[5]=0.
    task automatic test_i_type();
        logic [2:0] f3  [5];
        logic [2:0] alu [5];
        logic [3:0] st  [5];
        f3  = '{3'b000, 3'b010, 3'b110, 3'b111, 3'b001};
        alu = '{3'b000, 3'b101, 3'b011, 3'b010, 3'b000};
        st  = '{4'd0, 4'd1, 4'd8, 4'd7, 4'd0};
        op = 7'b0010011; funct7b5 = 1'b1; mem_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            funct3 = f3[k];
            for (int i = 0; i < 5; i++) begin
                #1;
                checks++; if (state !== st[i]) begin errors++; $display("FAIL itype_state f3=%b cyc%0d got %0d exp %0d", f3[k], i, state, st[i]); end
                if (i == 2) begin
                    checks++; if (ALUControl !== alu[k]) begin errors++; $display("FAIL itype_aluctl f3=%b got %b exp %b", f3[k], ALUControl, alu[k]); end
                    checks++; if (ALUSrcB !== 2'b01) begin errors++; $display("FAIL itype_alusrcb got %b exp 01", ALUSrcB); end
                end
                if (i == 3) begin
                    checks++; if (RegWrite !== 1'b1) begin errors++; $display("FAIL itype_regwrite got %b exp 1", RegWrite); end
                end
                if (i < 4) next_cycle();
            end
        end
        funct7b5 = 1'b0;
    endtask

    task automatic test_lw_stall();
        logic       mr [8];
        logic [3:0] st [8];
        logic       rw [8];
        mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        st = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
        rw = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        op = 7'b0000011; funct3 = 3'b010;
        for (int i = 0; i < 8; i++) begin
            mem_ready = mr[i];
            #1;
            checks++; if (state !== st[i]) begin errors++; $display("FAIL lw_state cyc%0d got %0d exp %0d", i, state, st[i]); end
            checks++; if (RegWrite !== rw[i]) begin errors++; $display("FAIL lw_regwrite cyc%0d got %b exp %b", i, RegWrite, rw[i]); end
            checks++; if (MemWrite !== 1'b0) begin errors++; $display("FAIL lw_memwrite cyc%0d got %b exp 0", i, MemWrite); end
            checks++; if (ImmSrc !== 2'b00) begin errors++; $display("FAIL lw_immsrc cyc%0d got %b exp 00", i, ImmSrc); end
            if (st[i] == 4'd3) begin
                checks++; if (AdrSrc !== 1'b1) begin errors++; $display("FAIL lw_adrsrc cyc%0d got %b exp 1", i, AdrSrc); end
            end
            if (st[i] == 4'd4) begin
                checks++; if (ResultSrc !== 2'b01) begin errors++; $display("FAIL lw_resultsrc got %b exp 01", ResultSrc); end
            end
            if (i < 7) next_cycle();
        end
    endtask

    task automatic test_sw();
        logic [3:0] st [5];
        logic       mw [5];
        st = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
        mw = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        op = 7'b0100011; funct3 = 3'b010; mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (state !== st[i]) begin errors++; $display("FAIL sw_state cyc%0d got %0d exp %0d", i, state, st[i]); end
            checks++; if (MemWrite !== mw[i]) begin errors++; $display("FAIL sw_memwrite cyc%0d got %b exp %b", i, MemWrite, mw[i]); end
            checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL sw_regwrite cyc%0d got %b exp 0", i, RegWrite); end
            checks++; if (ImmSrc !== 2'b01) begin errors++; $display("FAIL sw_immsrc cyc%0d got %b exp 01", i, ImmSrc); end
            if (i == 3) begin
                checks++; if (AdrSrc !== 1'b1) begin errors++; $display("FAIL sw_adrsrc got %b exp 1", AdrSrc); end
            end
            if (i < 4) next_cycle();
        end
    endtask

    task automatic test_beq(input logic z);
        logic [3:0] st  [4];
        logic       pcw [4];
        st  = '{4'd0, 4'd1, 4'd10, 4'd0};
        pcw = '{1'b1, 1'b0, z, 1'b1};
        op = 7'b1100011; funct3 = 3'b000; zero = z; mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (state !== st[i]) begin errors++; $display("FAIL beq_state z=%b cyc%0d got %0d exp %0d", z, i, state, st[i]); end
            checks++; if (PCWrite !== pcw[i]) begin errors++; $display("FAIL beq_pcwrite z=%b cyc%0d got %b exp %b", z, i, PCWrite, pcw[i]); end
            checks++; if (RegWrite !== 1'b0 || MemWrite !== 1'b0) begin errors++; $display("FAIL beq_strobes cyc%0d got rw=%b mw=%b exp 0 0", i, RegWrite, MemWrite); end
            if (i == 2) begin
                checks++; if (ALUControl !== 3'b001) begin errors++; $display("FAIL beq_aluctl got %b exp 001", ALUControl); end
                checks++; if (ImmSrc !== 2'b10) begin errors++; $display("FAIL beq_immsrc got %b exp 10", ImmSrc); end
            end
            if (i < 3) next_cycle();
        end
        zero = 1'b0;
    endtask

    task automatic test_jal();
        logic [3:0] st  [5];
        logic       pcw [5];
        logic       rw  [5];
        st  = '{4'd0, 4'd1, 4'd9, 4'd7, 4'd0};
        pcw = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        rw  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        op = 7'b1101111; mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (state !== st[i]) begin errors++; $display("FAIL jal_state cyc%0d got %0d exp %0d", i, state, st[i]); end
            checks++; if (PCWrite !== pcw[i]) begin errors++; $display("FAIL jal_pcwrite cyc%0d got %b exp %b", i, PCWrite, pcw[i]); end
            checks++; if (RegWrite !== rw[i]) begin errors++; $display("FAIL jal_regwrite cyc%0d got %b exp %b", i, RegWrite, rw[i]); end
            checks++; if (ImmSrc !== 2'b11) begin errors++; $display("FAIL jal_immsrc cyc%0d got %b exp 11", i, ImmSrc); end
            if (i == 2) begin
                checks++; if (ALUSrcA !== 2'b01 || ALUSrcB !== 2'b10) begin errors++; $display("FAIL jal_srcs got a=%b b=%b exp 01 10", ALUSrcA, ALUSrcB); end
            end
            if (i < 4) next_cycle();
        end
    endtask

    task automatic test_illegal();
        op = 7'b1111111; mem_ready = 1'b1;
        #1;
        checks++; if (state !== 4'd0) begin errors++; $display("FAIL ill_state0 got %0d exp 0", state); end
        checks++; if (ImmSrc !== 2'b00) begin errors++; $display("FAIL ill_immsrc got %b exp 00", ImmSrc); end
        next_cycle();
        #1;
        checks++; if (state !== 4'd1) begin errors++; $display("FAIL ill_state1 got %0d exp 1", state); end
        checks++; if (RegWrite !== 1'b0 || MemWrite !== 1'b0) begin errors++; $display("FAIL ill_decode_strobes got rw=%b mw=%b exp 0 0", RegWrite, MemWrite); end
        next_cycle();
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++; if (state !== 4'd11) begin errors++; $display("FAIL halt_state cyc%0d got %0d exp 11", i, state); end
            checks++; if (illegal_instr !== 1'b1) begin errors++; $display("FAIL halt_illegal cyc%0d got %b exp 1", i, illegal_instr); end
            checks++; if ({PCWrite, IRWrite, RegWrite, MemWrite} !== 4'b0000) begin
                errors++; $display("FAIL halt_strobes cyc%0d got %b exp 0000", i, {PCWrite, IRWrite, RegWrite, MemWrite});
            end
            next_cycle();
        end
        rst = 1'b1;
        #1;
        checks++; if (state !== 4'd0) begin errors++; $display("FAIL halt_rst_state got %0d exp 0", state); end
        checks++; if (illegal_instr !== 1'b0) begin errors++; $display("FAIL halt_rst_illegal got %b exp 0", illegal_instr); end
        rst = 1'b0;
`else
        #1;
        checks++; if (state !== 4'd0) begin errors++; $display("FAIL ill_nop_state got %0d exp 0", state); end
        checks++; if (illegal_instr !== 1'b0) begin errors++; $display("FAIL ill_nop_illegal got %b exp 0", illegal_instr); end
        checks++; if (RegWrite !== 1'b0 || MemWrite !== 1'b0) begin errors++; $display("FAIL ill_nop_strobes got rw=%b mw=%b exp 0 0", RegWrite, MemWrite); end
`endif
    endtask

    task automatic test_reset_mid_write();
        logic       mr [4];
        logic [3:0] st [4];
        mr = '{1'b1, 1'b1, 1'b1, 1'b0};
        st = '{4'd0, 4'd1, 4'd2, 4'd5};
        op = 7'b0100011;
        for (int i = 0; i < 4; i++) begin
            mem_ready = mr[i];
            #1;
            checks++; if (state !== st[i]) begin errors++; $display("FAIL mwrst_state cyc%0d got %0d exp %0d", i, state, st[i]); end
            if (i < 3) next_cycle();
        end
        next_cycle();
        checks++; if (state !== 4'd5 || MemWrite !== 1'b1) begin errors++; $display("FAIL mwrst_hold got st=%0d mw=%b exp 5 1", state, MemWrite); end
        rst = 1'b1;
        #1;
        checks++; if (state !== 4'd0) begin errors++; $display("FAIL mwrst_async_state got %0d exp 0", state); end
        checks++; if (MemWrite !== 1'b0) begin errors++; $display("FAIL mwrst_async_memwrite got %b exp 0", MemWrite); end
        checks++; if (PCWrite !== 1'b0 || IRWrite !== 1'b0) begin errors++; $display("FAIL mwrst_fetch_strobes got pc=%b ir=%b exp 0 0", PCWrite, IRWrite); end
        next_cycle();
        checks++; if (state !== 4'd0 || MemWrite !== 1'b0) begin errors++; $display("FAIL mwrst_held got st=%0d mw=%b exp 0 0", state, MemWrite); end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b1;
        test_reset();
        test_r_type(1'b0);
        test_r_type(1'b1);
        test_i_type();
        test_lw_stall();
        test_sw();
        test_beq(1'b1);
        test_beq(1'b0);
        test_jal();
        test_illegal();
        test_reset_mid_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
